// File: rtl/spiker_seq_pkg.sv
// spiker_seq_pkg: shared types and constants for the spiker inference sequencer.
//   spiker_seq_state_e : sequencer FSM state encoding
//   CNT_W              : width of the inference latency counter
//   idx_width()        : width of a word index covering n words (at least 1)
package spiker_seq_pkg;

    localparam int CNT_W = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_KICK,
        S_RUN,
        S_SAMPLE,
        S_DRAIN
    } spiker_seq_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spiker_sat_counter.sv
// spiker_sat_counter: up-counter with synchronous clear, enable and saturation.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset (count -> 0)
//   clr_i  : synchronous clear, wins over enable
//   en_i   : count enable; the count sticks at all-ones
//   cnt_o  : current count
module spiker_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/spiker_sequencer.sv
// spiker_sequencer: sequences one spiker inference end to end.
//   start_i/abort_i          : control requests (start may be a level)
//   in_idx_o/in_word_i       : register-file input word select and returned word
//   core_data_o/core_load_o  : word stream into the core (data valid with load)
//   core_start_o/core_ready_i: one-cycle core kick and core idle/finished
//   sample_o/writer_ready_i  : one-cycle capture pulse and writer free
//   busy_o/done_o/timeout_o  : status (done/timeout sticky until next start)
//   cycle_cnt_o              : saturating inference latency in cycles
module spiker_sequencer
    import spiker_seq_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int N_IN_WORDS     = 25,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int IDX_W          = idx_width(N_IN_WORDS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    output logic [IDX_W-1:0] in_idx_o,
    input  logic [WIDTH-1:0] in_word_i,
    output logic [WIDTH-1:0] core_data_o,
    output logic             core_load_o,
    output logic             core_start_o,
    input  logic             core_ready_i,
    output logic             sample_o,
    input  logic             writer_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] cycle_cnt_o
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES);

    spiker_seq_state_e state_q;
    logic [IDX_W-1:0]  idx_q;
    logic              load_q, kick_q, sample_q, busy_q, done_q, timeout_q;
    logic              low_seen_q;   // DRAIN has seen the writer go busy

    logic [TO_W-1:0]   tmo_cnt;
    logic              accept, tmo_hit, first_run;

    assign accept    = (state_q == S_IDLE) && start_i && writer_ready_i;
    // The timer is cleared in KICK, so it reads 0 in the first RUN cycle,
    // the cycle in which a stale ready from before the kick must be ignored.
    assign first_run = (tmo_cnt == '0);
    assign tmo_hit   = (tmo_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    spiker_sat_counter #(.W(TO_W)) u_tmo_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (state_q == S_KICK),
        .en_i  (state_q == S_RUN),
        .cnt_o (tmo_cnt)
    );

    spiker_sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (accept),
        .en_i  (state_q != S_IDLE),
        .cnt_o (cycle_cnt_o)
    );

    // Strobes are registered decodes of the state being entered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            load_q     <= 1'b0;
            kick_q     <= 1'b0;
            sample_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            low_seen_q <= 1'b0;
        end else begin
            load_q   <= 1'b0;
            kick_q   <= 1'b0;
            sample_q <= 1'b0;
            if (abort_i && (state_q != S_IDLE)) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                idx_q   <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (accept) begin
                            state_q   <= S_LOAD;
                            busy_q    <= 1'b1;
                            done_q    <= 1'b0;
                            timeout_q <= 1'b0;
                            idx_q     <= '0;
                            load_q    <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        if (idx_q == IDX_W'(N_IN_WORDS - 1)) begin
                            state_q <= S_KICK;
                            idx_q   <= '0;
                            kick_q  <= 1'b1;
                        end else begin
                            idx_q  <= idx_q + IDX_W'(1);
                            load_q <= 1'b1;
                        end
                    end
                    S_KICK: state_q <= S_RUN;
                    S_RUN: begin
                        // Ready beats a timeout landing on the same cycle.
                        if (core_ready_i && !first_run) begin
                            state_q <= S_SAMPLE;
                        end else if (tmo_hit) begin
                            state_q   <= S_IDLE;
                            busy_q    <= 1'b0;
                            timeout_q <= 1'b1;
                        end
                    end
                    S_SAMPLE: begin
                        if (writer_ready_i) begin
                            state_q    <= S_DRAIN;
                            sample_q   <= 1'b1;
                            low_seen_q <= 1'b0;
                        end
                    end
                    S_DRAIN: begin
                        // Writer must first go busy with the sample, then free again.
                        if (!writer_ready_i) begin
                            low_seen_q <= 1'b1;
                        end else if (low_seen_q) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign in_idx_o     = idx_q;
    assign core_data_o  = load_q ? in_word_i : '0;
    assign core_load_o  = load_q;
    assign core_start_o = kick_q;
    assign sample_o     = sample_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_spiker_sequencer.sv
// tb_spiker_sequencer: directed stimulus with a queue scoreboard. Stimulus pushes
// the expected load words and per-inference results; a negedge monitor pops them
// as the DUT presents loads and as busy falls at the end of each inference.
module tb_spiker_sequencer;

    localparam int N = 25;
    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1, start = 1'b0, abort = 1'b0;
    logic        core_ready, wr_ready;
    logic [4:0]  in_idx;
    logic [31:0] in_word, core_data, cycle_cnt;
    logic        core_load, core_start, sample, busy, done, timeout;

    logic [31:0] word_base = 32'h100;
    int          core_lat  = 10;   // ready returns core_lat cycles after the kick cycle; 0 = never
    int          core_cnt;
    logic        core_rdy_q, wr_rdy_q;
    logic        wr_hold = 1'b0;

    assign in_word    = word_base + 32'(in_idx);
    assign core_ready = core_rdy_q;
    assign wr_ready   = wr_rdy_q & ~wr_hold;

    always #5 clk = ~clk;

    spiker_sequencer #(.WIDTH(32), .N_IN_WORDS(N), .TIMEOUT_CYCLES(T)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
        .in_idx_o(in_idx), .in_word_i(in_word),
        .core_data_o(core_data), .core_load_o(core_load), .core_start_o(core_start),
        .core_ready_i(core_ready), .sample_o(sample), .writer_ready_i(wr_ready),
        .busy_o(busy), .done_o(done), .timeout_o(timeout), .cycle_cnt_o(cycle_cnt)
    );

    // Core and writer models. The writer goes busy for the one cycle after a sample.
    always @(posedge clk) begin
        if (rst) begin
            core_rdy_q <= 1'b1;
            core_cnt   <= 0;
            wr_rdy_q   <= 1'b1;
        end else begin
            if (core_start) begin
                core_rdy_q <= 1'b0;
                core_cnt   <= (core_lat == 0) ? 0 : core_lat - 1;
            end else if (core_cnt != 0) begin
                core_cnt <= core_cnt - 1;
                if (core_cnt == 1) core_rdy_q <= 1'b1;
            end
            wr_rdy_q <= !sample;
        end
    end

    typedef struct {
        logic        done;
        logic        tmo;
        logic [31:0] cnt;
        int          starts;
        int          samples;
    } res_t;

    logic [31:0] load_exp[$];
    res_t        res_exp[$];
    int          checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_loads(input int n);
        for (int i = 0; i < n; i++) load_exp.push_back(word_base + 32'(i));
    endtask

    task automatic push_res(input logic d, input logic t, input int c, input int s, input int sa);
        res_t r;
        r.done = d; r.tmo = t; r.cnt = 32'(c); r.starts = s; r.samples = sa;
        res_exp.push_back(r);
    endtask

    // Monitor / scoreboard
    int   n_st = 0, n_sa = 0;
    logic pbusy = 1'b0;
    initial begin
        res_t        r;
        logic [31:0] w;
        forever begin
            @(negedge clk);
            if (rst) begin
                n_st = 0; n_sa = 0; pbusy = 1'b0;
            end else begin
                if (core_load) begin
                    if (load_exp.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_load: idx %0d data %0h, none expected", in_idx, core_data);
                    end else begin
                        w = load_exp.pop_front();
                        chk("load_data", core_data, w);
                    end
                end
                if (core_start) n_st++;
                if (sample) n_sa++;
                if (pbusy && !busy) begin
                    if (res_exp.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_end: cnt %0d, no result expected", cycle_cnt);
                    end else begin
                        r = res_exp.pop_front();
                        chk("done", 32'(done), 32'(r.done));
                        chk("timeout", 32'(timeout), 32'(r.tmo));
                        chk("cycle_cnt", cycle_cnt, r.cnt);
                        chk("core_starts", 32'(n_st), 32'(r.starts));
                        chk("samples", 32'(n_sa), 32'(r.samples));
                    end
                    n_st = 0; n_sa = 0;
                end
                pbusy = busy;
            end
        end
    end

    function automatic bit hit(input int k, input int a);
        case (k)
            0: return busy;
            1: return !busy;
            2: return core_start;
            3: return sample;
            4: return core_load && (in_idx == 5'(a));
            default: return 1'b0;
        endcase
    endfunction

    // Returns at the negedge where the condition first holds (bounded).
    task automatic wait_for(input int k, input int a, input string nm);
        int n = 0;
        do begin @(negedge clk); n++; end while (!hit(k, a) && n < 400);
        if (!hit(k, a)) begin
            checks++; failures++;
            $display("FAIL wait_%s: event not seen within %0d cycles", nm, n);
        end
    endtask

    task automatic start_pulse();
        @(posedge clk); #1 start = 1'b1;
        wait_for(0, 0, "accept");
        @(posedge clk); #1 start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_flags", {30'd0, done, timeout}, 0);
        chk("rst_strobes", {29'd0, core_load, core_start, sample}, 0);
        chk("rst_idx", 32'(in_idx), 0);
        chk("rst_data", core_data, 0);
        chk("rst_cycle_cnt", cycle_cnt, 0);
        rst = 1'b0;

        // Nominal: LOAD 25 + KICK 1 + RUN 10 + SAMPLE 1 + DRAIN 3 = 40
        word_base = 32'h100; core_lat = 10;
        push_loads(N); push_res(1'b1, 1'b0, 40, 1, 1);
        start_pulse();
        wait_for(1, 0, "idle_nominal");
        repeat (3) @(negedge clk);
        chk("done_sticky", 32'(done), 1);
        chk("cnt_holds", cycle_cnt, 40);

        // Timeout: 25 + 1 + 16 RUN cycles = 42
        word_base = 32'hDEAD_0000; core_lat = 0;
        push_loads(N); push_res(1'b0, 1'b1, 42, 1, 0);
        start_pulse();
        wait_for(1, 0, "idle_timeout");

        // Writer busy for 5 cycles from SAMPLE entry: SAMPLE 6, total 39
        word_base = 32'h5A5A_5A00; core_lat = 4;
        push_loads(N); push_res(1'b1, 1'b0, 39, 1, 1);
        start_pulse();
        wait_for(2, 0, "kick_wbusy");
        repeat (5) @(posedge clk);
        #1 wr_hold = 1'b1;
        repeat (5) @(posedge clk);
        #1 wr_hold = 1'b0;
        wait_for(1, 0, "idle_wbusy");

        // Start held off by a busy writer, then abort at LOAD index 7: 8 loads, cnt 8
        word_base = 32'h0000_7700;
        @(posedge clk); #1 wr_hold = 1'b1; start = 1'b1;
        repeat (3) @(negedge clk);
        chk("held_off_busy", 32'(busy), 0);
        push_loads(8); push_res(1'b0, 1'b0, 8, 0, 0);
        @(posedge clk); #1 wr_hold = 1'b0;
        wait_for(0, 0, "accept_held");
        @(posedge clk); #1 start = 1'b0;
        wait_for(4, 7, "load_idx7");
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        wait_for(1, 0, "idle_abort_load");

        // Abort in the third RUN cycle (cycle 29)
        word_base = 32'h3300; core_lat = 0;
        push_loads(N); push_res(1'b0, 1'b0, 29, 1, 0);
        start_pulse();
        wait_for(2, 0, "kick_abort_run");
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        wait_for(1, 0, "idle_abort_run");

        // Synchronous reset in DRAIN, then a normal run (25+1+3+1+3 = 33)
        word_base = 32'h0C00; core_lat = 3;
        push_loads(N);
        start_pulse();
        wait_for(3, 0, "sample_before_rst");
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("drain_rst_busy", 32'(busy), 0);
        chk("drain_rst_strobes", {29'd0, core_load, core_start, sample}, 0);
        chk("drain_rst_flags", {30'd0, done, timeout}, 0);
        chk("drain_rst_cnt", cycle_cnt, 0);
        chk("drain_rst_idx_data", core_data | 32'(in_idx), 0);
        rst = 1'b0;
        push_loads(N); push_res(1'b1, 1'b0, 33, 1, 1);
        start_pulse();
        wait_for(1, 0, "idle_after_rst");

        // Held start: back-to-back runs. First has ready on the timeout cycle (46),
        // second is a short run (33).
        word_base = 32'hBEEF_0000; core_lat = 16;
        push_loads(N); push_res(1'b1, 1'b0, 46, 1, 1);
        push_loads(N); push_res(1'b1, 1'b0, 33, 1, 1);
        @(posedge clk); #1 start = 1'b1;
        wait_for(2, 0, "kick_tie");
        @(posedge clk); #1 core_lat = 3;
        wait_for(1, 0, "idle_tie");
        wait_for(2, 0, "kick_second");
        @(posedge clk); #1 start = 1'b0;
        wait_for(1, 0, "idle_second");
        chk("final_done", 32'(done), 1);
        chk("final_timeout", 32'(timeout), 0);

        repeat (4) @(negedge clk);
        chk("load_queue_empty", 32'(load_exp.size()), 0);
        chk("result_queue_empty", 32'(res_exp.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spiker_sequencer.md
# spiker_sequencer

Control FSM that sequences one spiker inference end to end. It streams the input spike words from the register file into the spiker core, kicks the core, and waits for completion with a timeout. It then hands the result to the output writer through the writer's `sample`/`ready` handshake. It sits between the control/status registers and the spiker core plus writer datapath.

## Interface
Parameters:
- `WIDTH`, 32: spike word width.
- `N_IN_WORDS`, 25: input words per inference (784 spikes, padded to 800).
- `TIMEOUT_CYCLES`, 65536: maximum RUN cycles before the sequencer aborts.
- `IDX_W`, `$clog2(N_IN_WORDS)`: index width.

Ports:
- `clk_i`, in, 1: single clock.
- `rst_i`, in, 1: synchronous, active-high reset.
- `start_i`, in, 1: start request from the control register (level or pulse).
- `abort_i`, in, 1: cancel the current inference.
- `in_idx_o`, out, `IDX_W`: register-file input word select.
- `in_word_i`, in, `WIDTH`: input word. It is a combinational function of `in_idx_o`.
- `core_data_o`, out, `WIDTH`: word to the core.
- `core_load_o`, out, 1: core load strobe.
- `core_start_o`, out, 1: one-cycle core start pulse.
- `core_ready_i`, in, 1: core idle/finished.
- `sample_o`, out, 1: one-cycle capture pulse to the writer.
- `writer_ready_i`, in, 1: writer free.
- `busy_o`, out, 1: high whenever the FSM is not in IDLE.
- `done_o`, out, 1: sticky success flag.
- `timeout_o`, out, 1: sticky timeout flag.
- `cycle_cnt_o`, out, 32: inference latency, saturating.

## Operation
States: IDLE, LOAD, KICK, RUN, SAMPLE, DRAIN.

- **IDLE**
  - `start_i=1` and `writer_ready_i=1` → LOAD.
  - On that transition: clear `done_o`/`timeout_o`, set `in_idx_o=0` and `cycle_cnt_o=0`.
  - `start_i` with `writer_ready_i=0` is held off and not lost while it remains high.
- **LOAD**
  - Every cycle: `core_load_o=1`, `core_data_o=in_word_i` (pass-through), `in_idx_o` increments.
  - Exactly `N_IN_WORDS` load cycles with indices 0..N-1.
  - After index N-1 → KICK; `in_idx_o` returns to 0.
- **KICK**
  - `core_start_o=1` for one cycle, then → RUN.
  - Clear the timeout counter.
- **RUN**
  - `core_ready_i` is ignored in the first RUN cycle; the core drops ready within one cycle of the start pulse.
  - `core_ready_i=1` → SAMPLE.
  - Timeout counter reaching `TIMEOUT_CYCLES-1` without ready → `timeout_o=1`, → IDLE, no sample pulse.
- **SAMPLE**
  - Wait for `writer_ready_i=1`, then `sample_o=1` for one cycle → DRAIN.
- **DRAIN**
  - First wait for `writer_ready_i=0`, then for `writer_ready_i=1`.
  - On the rising return: `done_o=1`, → IDLE.
- **abort_i** in any non-IDLE state:
  - → IDLE next cycle.
  - All strobes are 0 from that cycle; `done_o` and `timeout_o` stay 0.
  - `abort_i` has priority over every other transition and is ignored in IDLE.
- **cycle_cnt_o**: increments every cycle from LOAD entry through DRAIN, holds in IDLE, saturates at `32'hFFFF_FFFF`.
- **start_i while busy**: ignored. It starts a new inference only if still high once the FSM is back in IDLE.

## Timing
- **Reset** (`rst_i` high at a clock edge): state=IDLE.
  - All outputs 0, including `in_idx_o`, `core_data_o`, the flags and `cycle_cnt_o`.
  - Reset mid-inference discards everything with no residual pulse.
- **Output registration**
  - `core_load_o`, `core_start_o` and `sample_o` are registered state decodes; no glitching.
  - `core_data_o` is combinational from `in_word_i`, valid exactly while `core_load_o=1`.
- **Minimum latency** (start accepted at cycle 0, zero-delay core and writer):
  - LOAD: cycles 1..N.
  - KICK: cycle N+1.
  - RUN: ≥2 cycles.
  - SAMPLE: 1 cycle.
  - DRAIN: ≥2 cycles.
- **Simultaneous `core_ready_i` and timeout in the same RUN cycle**: ready wins, no timeout.
- **`busy_o`**: equals state≠IDLE, registered.

## Structure
- Package `spiker_seq_pkg` holds:
  - the state enum `spiker_seq_state_e`;
  - the `IDX_W` helper;
  - the `CNT_W=32` constant.
- Sub-module `spiker_sat_counter` (clear, enable, saturate, parameterised width) is instantiated twice:
  - the RUN timeout counter, width `$clog2(TIMEOUT_CYCLES)`;
  - `cycle_cnt_o`.
- Everything else lives in one FSM module.

## Test plan
- **Nominal run** (N_IN_WORDS=25, words 0x100+i, core ready 10 cycles after start, writer drops ready for 1 cycle): exactly 25 loads carrying 0x100..0x118 in order; one `core_start_o`; one `sample_o`; `done_o=1`; `cycle_cnt_o`=40.
- **Timeout** (`TIMEOUT_CYCLES`=16, core never ready): `timeout_o=1` after 16 RUN cycles; `sample_o` never asserts; `busy_o=0`.
- **Writer busy** (`writer_ready_i=0` for 5 cycles when RUN completes): `sample_o` delayed until ready=1, exactly one pulse.
- **Abort** at LOAD index 7, and again mid-RUN: next cycle IDLE, no further load/start/sample pulses, `done_o=0`.
- **Synchronous reset** asserted in DRAIN: all outputs 0 on the following cycle; a subsequent start runs normally.
- **Held start and ready/timeout tie**: `start_i` held high through a run triggers back-to-back inferences. `core_ready_i` rising on the timeout cycle yields `done_o=1` and `timeout_o=0`.
